// File: rtl/scoreboard_regfile_pkg.sv
// Shared defaults and FSM state type for the scoreboarded register file.
package regfile_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage : regfile_pkg

// File: rtl/scoreboard_regfile_if.sv
// Decode/writeback-facing bus of the register file: reads, writes, reserve and clear.
interface scoreboard_regfile_if #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
);

    logic [ADDR_W-1:0] SrcReg1;
    logic [ADDR_W-1:0] SrcReg2;
    logic [WIDTH-1:0]  SrcData1;
    logic [WIDTH-1:0]  SrcData2;
    logic              Busy1;
    logic              Busy2;
    logic              WriteReg;
    logic [ADDR_W-1:0] DstReg;
    logic [WIDTH-1:0]  DstData;
    logic              Reserve;
    logic [ADDR_W-1:0] ResReg;
    logic              ClearReq;
    logic              ClearBusy;
    logic [ADDR_W:0]   PendCount;

    modport master (
        output SrcReg1, SrcReg2, WriteReg, DstReg, DstData,
               Reserve, ResReg, ClearReq,
        input  SrcData1, SrcData2, Busy1, Busy2, ClearBusy, PendCount
    );

    modport slave (
        input  SrcReg1, SrcReg2, WriteReg, DstReg, DstData,
               Reserve, ResReg, ClearReq,
        output SrcData1, SrcData2, Busy1, Busy2, ClearBusy, PendCount
    );

endinterface : scoreboard_regfile_if

// File: rtl/scoreboard_regfile_reg_scoreboard.sv
// Per-register busy bits: release on writeback, set on reserve (set wins),
// wipe during bulk clear, registered popcount and per-port busy lookup.
module reg_scoreboard #(
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_idx,
    input  logic              rel_en,
    input  logic [ADDR_W-1:0] rel_idx,
    input  logic              wipe_en,
    input  logic [ADDR_W-1:0] wipe_idx,
    input  logic [ADDR_W-1:0] rd_idx1,
    input  logic [ADDR_W-1:0] rd_idx2,
    input  logic              hit1,
    input  logic              hit2,
    input  logic              force_busy,
    output logic              busy1,
    output logic              busy2,
    output logic [ADDR_W:0]   pend_count
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [ADDR_W:0]  pend_q;
    logic [ADDR_W:0]  pend_d;

    always_comb begin
        busy_d = busy_q;
        if (rel_en) begin
            busy_d[rel_idx] = 1'b0;
        end
        if (set_en) begin
            busy_d[set_idx] = 1'b1;
        end
        if (wipe_en) begin
            busy_d[wipe_idx] = 1'b0;
        end
        if (ZERO_REG) begin
            busy_d[0] = 1'b0;
        end
    end

    // Count the next-state vector so the register tracks busy_q exactly.
    always_comb begin
        pend_d = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            pend_d = pend_d + {{ADDR_W{1'b0}}, busy_d[i]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
            pend_q <= '0;
        end else begin
            busy_q <= busy_d;
            pend_q <= pend_d;
        end
    end

    always_comb begin
        busy1 = force_busy | (busy_q[rd_idx1] & ~hit1);
        busy2 = force_busy | (busy_q[rd_idx2] & ~hit2);
    end

    assign pend_count = pend_q;

endmodule : reg_scoreboard

// File: rtl/scoreboard_regfile.sv
// Register file with write-to-read bypass, optional hardwired R0,
// busy scoreboard and a sequenced one-register-per-cycle bulk clear.
module scoreboard_regfile
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    scoreboard_regfile_if.slave  bus
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];

    logic idle;
    logic wr_legal;
    logic res_legal;
    logic hit1;
    logic hit2;

    always_comb begin
        idle      = (state_q == IDLE);
        wr_legal  = idle & bus.WriteReg & ~(ZERO_REG && (bus.DstReg == '0));
        res_legal = idle & bus.Reserve  & ~(ZERO_REG && (bus.ResReg == '0));
        hit1      = wr_legal & (bus.DstReg == bus.SrcReg1);
        hit2      = wr_legal & (bus.DstReg == bus.SrcReg2);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_d   = mem_q;
        unique case (state_q)
            IDLE: begin
                if (wr_legal) begin
                    mem_d[bus.DstReg] = bus.DstData;
                end
                if (bus.ClearReq) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                mem_d[cnt_q] = '0;
                cnt_d        = cnt_q + 1'b1;
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mem_q   <= mem_d;
        end
    end

    always_comb begin
        bus.SrcData1 = hit1 ? bus.DstData : mem_q[bus.SrcReg1];
        bus.SrcData2 = hit2 ? bus.DstData : mem_q[bus.SrcReg2];
        if (ZERO_REG && (bus.SrcReg1 == '0)) begin
            bus.SrcData1 = '0;
        end
        if (ZERO_REG && (bus.SrcReg2 == '0)) begin
            bus.SrcData2 = '0;
        end
        bus.ClearBusy = ~idle;
    end

    reg_scoreboard #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .set_en     (res_legal),
        .set_idx    (bus.ResReg),
        .rel_en     (wr_legal),
        .rel_idx    (bus.DstReg),
        .wipe_en    (~idle),
        .wipe_idx   (cnt_q),
        .rd_idx1    (bus.SrcReg1),
        .rd_idx2    (bus.SrcReg2),
        .hit1       (hit1),
        .hit2       (hit2),
        .force_busy (~idle),
        .busy1      (bus.Busy1),
        .busy2      (bus.Busy2),
        .pend_count (bus.PendCount)
    );

endmodule : scoreboard_regfile

// File: tb/tb_scoreboard_regfile.sv
// Randomised scoreboard bench for scoreboard_regfile against an array-based model.
module tb_scoreboard_regfile;

    localparam int W  = 16;
    localparam int D  = 16;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    scoreboard_regfile_if #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW)) bus_if ();

    scoreboard_regfile #(
        .WIDTH    (W),
        .DEPTH    (D),
        .ADDR_W   (AW),
        .ZERO_REG (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d1;
        logic [15:0] d2;
        logic        b1;
        logic        b2;
        logic        cb;
        logic [4:0]  pc;
    } exp_t;

    exp_t expq[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model state
    int unsigned mem_m [D];
    bit          busy_m[D];
    int          clear_left = 0;
    int          clear_idx  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("SrcData1",  32'(bus_if.SrcData1),  32'(e.d1));
                check("SrcData2",  32'(bus_if.SrcData2),  32'(e.d2));
                check("Busy1",     32'(bus_if.Busy1),     32'(e.b1));
                check("Busy2",     32'(bus_if.Busy2),     32'(e.b2));
                check("ClearBusy", 32'(bus_if.ClearBusy), 32'(e.cb));
                check("PendCount", 32'(bus_if.PendCount), 32'(e.pc));
            end
        end
    end

    function automatic void model_reset();
        for (int i = 0; i < D; i++) begin
            mem_m[i]  = 0;
            busy_m[i] = 0;
        end
        clear_left = 0;
        clear_idx  = 0;
    endfunction

    function automatic int unsigned pend_m();
        int unsigned n = 0;
        for (int i = 0; i < D; i++) n += busy_m[i];
        return n;
    endfunction

    // Drive one cycle: apply inputs, predict visible outputs, then advance the model
    // over the coming rising edge.
    task automatic cycle(input bit we, input int dst, input int dd, input bit res,
                         input int rid, input bit creq, input int s1, input int s2);
        exp_t e;
        bit   in_clear;
        bit   legal_wr;
        @(posedge clk);
        #1;
        bus_if.WriteReg = we;
        bus_if.DstReg   = AW'(dst);
        bus_if.DstData  = W'(dd);
        bus_if.Reserve  = res;
        bus_if.ResReg   = AW'(rid);
        bus_if.ClearReq = creq;
        bus_if.SrcReg1  = AW'(s1);
        bus_if.SrcReg2  = AW'(s2);

        in_clear = (clear_left > 0);
        legal_wr = !in_clear && we && (dst != 0);
        e.d1 = (s1 == 0) ? 16'h0 : (legal_wr && dst == s1) ? 16'(dd) : 16'(mem_m[s1]);
        e.d2 = (s2 == 0) ? 16'h0 : (legal_wr && dst == s2) ? 16'(dd) : 16'(mem_m[s2]);
        e.b1 = in_clear ? 1'b1 : (busy_m[s1] && !(legal_wr && dst == s1));
        e.b2 = in_clear ? 1'b1 : (busy_m[s2] && !(legal_wr && dst == s2));
        e.cb = in_clear;
        e.pc = 5'(pend_m());
        expq.push_back(e);

        if (in_clear) begin
            mem_m[clear_idx]  = 0;
            busy_m[clear_idx] = 0;
            clear_idx++;
            clear_left--;
        end else begin
            if (legal_wr) begin
                mem_m[dst]  = dd;
                busy_m[dst] = 0;
            end
            if (res && rid != 0) busy_m[rid] = 1;
            if (creq) begin
                clear_left = D;
                clear_idx  = 0;
            end
        end
    endtask

    // Assert reset between edges and expect reset values before any further edge.
    task automatic reset_mid();
        exp_t e;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus_if.WriteReg = 1'b0;
        bus_if.DstReg   = '0;
        bus_if.DstData  = '0;
        bus_if.Reserve  = 1'b0;
        bus_if.ResReg   = '0;
        bus_if.ClearReq = 1'b0;
        bus_if.SrcReg1  = AW'($urandom_range(1, D - 1));
        bus_if.SrcReg2  = AW'($urandom_range(1, D - 1));
        model_reset();
        e.d1 = '0; e.d2 = '0; e.b1 = 1'b0; e.b2 = 1'b0; e.cb = 1'b0; e.pc = '0;
        expq.push_back(e);
        @(negedge clk);
        #2;
        rst = 1'b1;
    endtask

    task automatic idle_read(input int s1, input int s2);
        cycle(0, 0, 0, 0, 0, 0, s1, s2);
    endtask

    initial begin : stimulus
        bus_if.WriteReg = 1'b0;
        bus_if.DstReg   = '0;
        bus_if.DstData  = '0;
        bus_if.Reserve  = 1'b0;
        bus_if.ResReg   = '0;
        bus_if.ClearReq = 1'b0;
        bus_if.SrcReg1  = '0;
        bus_if.SrcReg2  = '0;
        model_reset();

        reset_mid();

        // Write and bypass
        cycle(1, 2, 6, 0, 0, 0, 2, 3);
        cycle(1, 8, 10, 0, 0, 0, 2, 8);
        idle_read(8, 2);

        // Hardwired R0
        cycle(1, 0, 'hFFFF, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0, 0, 0);
        idle_read(0, 0);

        // Reserve then release by writeback
        cycle(0, 0, 0, 1, 5, 0, 1, 1);
        idle_read(5, 1);
        cycle(1, 5, 'h1234, 0, 0, 0, 5, 5);
        idle_read(5, 5);

        // Reserve and write the same register in one cycle
        cycle(1, 7, 'hBEEF, 1, 7, 0, 7, 6);
        idle_read(7, 7);

        // Fill, reserve a few, then bulk clear with traffic dropped during it
        for (int r = 1; r < D; r++) cycle(1, r, 'hA5A5, 0, 0, 0, r, 0);
        cycle(0, 0, 0, 1, 3, 0, 3, 9);
        cycle(1, 4, 'h5A5A, 1, 9, 1, 3, 9);
        for (int k = 0; k < D + 1; k++)
            cycle(1, $urandom_range(0, D - 1), $urandom_range(0, 65535), 1,
                  $urandom_range(0, D - 1), 1, $urandom_range(0, D - 1), $urandom_range(0, D - 1));
        for (int k = 0; k < D / 2; k++) idle_read(2 * k, 2 * k + 1);

        // Reset mid-reservation and mid-clear
        cycle(1, 11, 'h7777, 1, 4, 0, 4, 11);
        cycle(0, 0, 0, 1, 6, 1, 4, 6);
        for (int k = 0; k < 5; k++) idle_read(4, 6);
        reset_mid();
        for (int k = 0; k < D / 2; k++) idle_read(2 * k, 2 * k + 1);

        // Randomised traffic
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 499) == 0) begin
                reset_mid();
            end else begin
                cycle($urandom_range(0, 1), $urandom_range(0, D - 1), $urandom_range(0, 65535),
                      $urandom_range(0, 2) == 0, $urandom_range(0, D - 1),
                      $urandom_range(0, 63) == 0,
                      $urandom_range(0, D - 1), $urandom_range(0, D - 1));
            end
        end

        for (int k = 0; k < 10 && expq.size() > 0; k++) @(negedge clk);
        #1;
        if (expq.size() > 0) begin
            n_checks++;
            $display("FAIL drain actual=%0d expected=0 pending entries", expq.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_scoreboard_regfile

// File: doc/scoreboard_regfile.md
# scoreboard_regfile

Parametrised general-purpose register file for the 16-bit pipelined core, replacing the fixed 16×16 register file. Adds same-cycle write-to-read bypass, an optional hardwired-zero register 0, a per-register busy scoreboard with reserve/release handshake for hazard detection, and a sequenced bulk-clear mode. It sits between decode (reads, reserve) and writeback (writes, release).

## Interface
- WIDTH, 16, data width in bits
- DEPTH, 16, number of registers (power of two, ≥2)
- ADDR_W, $clog2(DEPTH), register index width
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- SrcReg1, SrcReg2  in  ADDR_W  read indices
- SrcData1, SrcData2  out  WIDTH  read data (combinational)
- Busy1, Busy2  out  1  source register has an outstanding reservation
- WriteReg  in  1  write enable (writeback)
- DstReg  in  ADDR_W  write index
- DstData  in  WIDTH  write data
- Reserve  in  1  mark ResReg busy (issue of a producing instruction)
- ResReg  in  ADDR_W  index to reserve
- ClearReq  in  1  start bulk clear (sampled in IDLE only)
- ClearBusy  out  1  clear sequence in progress
- PendCount  out  ADDR_W+1  number of busy registers

## Operation
- Array: DEPTH × WIDTH flops; busy: DEPTH bits; FSM: IDLE, CLEAR; clear counter ADDR_W bits.
- Write (IDLE only): rising edge with WriteReg=1 stores DstData at DstReg and clears busy[DstReg]. Ignored for DstReg=0 when ZERO_REG=1.
- Read: SrcDataX = array[SrcRegX]; in IDLE, if WriteReg=1, DstReg=SrcRegX and the write is legal, SrcDataX = DstData (bypass). ZERO_REG=1 and SrcRegX=0 → 0 always.
- Reserve (IDLE only): sets busy[ResReg] at the edge. ResReg=0 with ZERO_REG=1 ignored. Reserve and write of the same register in one cycle: reserve wins (busy stays 1, data written).
- BusyX = busy[SrcRegX] & ~(legal bypass hit on SrcRegX) in IDLE; forced 1 in CLEAR.
- PendCount = popcount(busy), registered value (reflects state after last edge).
- ClearReq=1 in IDLE → CLEAR next cycle, counter=0. Each CLEAR cycle zeroes array[counter] and busy[counter], counter increments; after index DEPTH-1 → IDLE. ClearReq in CLEAR ignored. Writes and reserves in CLEAR are dropped. ClearReq takes priority over a same-cycle write/reserve (those are still performed in that IDLE cycle, then cleared by the sequence).
- Reads in CLEAR: array contents, no bypass.

## Timing
- Reset (rst=0, async): array all 0, busy all 0, state IDLE, counter 0; ClearBusy=0, PendCount=0, Busy1=Busy2=0, SrcData=0.
- Write-to-array latency 1 cycle; bypass latency 0.
- Reserve visible on BusyX and PendCount the cycle after the edge.
- ClearBusy=1 from the cycle after ClearReq is sampled, for exactly DEPTH cycles.
- Reset asserted mid-CLEAR aborts immediately to reset state.
- PendCount range 0..DEPTH (width ADDR_W+1 holds DEPTH).

## Structure
- Package regfile_pkg: default WIDTH/DEPTH, state enum (IDLE, CLEAR).
- Sub-module reg_scoreboard: busy vector, set/clear priority, popcount, BusyX lookup; parameters DEPTH, ZERO_REG.
- Top holds array, bypass mux, FSM and counter.

## Test plan
- Reset, write 6 to R2, then SrcReg1=2 → SrcData1=6; same-cycle WriteReg to R8 with DstData=10, SrcReg2=8 → SrcData2=10 before the edge.
- ZERO_REG=1: write 0xFFFF to R0, read R0 → 0; Reserve R0 → Busy stays 0, PendCount 0.
- Reserve R5 → next cycle Busy1=1 (SrcReg1=5), PendCount=1; write R5=0x1234 → Busy1=0 in the write cycle (bypass), PendCount=0 after.
- Reserve and write R7 same cycle → R7=written data, Busy remains 1, PendCount=1.
- Fill R1..R15 with 0xA5A5, ClearReq → ClearBusy high 16 cycles, Busy1/2=1 throughout, writes during clear dropped, afterwards all reads 0, PendCount=0.
- rst low mid-clear and mid-reservation → all outputs return to reset values asynchronously.
